float_copro_seq: RTL and testbench

- Command sequencer between the LM32 custom-instruction port and the shared multi-cycle float unit (add/sub/mul/div).
- Accepts one command at a time, latches the operands, and decodes the opcode.
- Handles the zero and divide-by-zero fast paths itself; otherwise issues a start pulse to the unit and waits for its done signal.
- Returns a registered result over a valid/ready response handshake.

---
 rtl/float_copro_seq.sv | 167 ++++++++++++++++
 tb/tb_float_copro_seq.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/float_copro_seq.sv
// Sequencer between the LM32 custom-instruction port and the shared multi-cycle float unit.
// Define FLOAT_COPRO_TIMEOUT_EN to add a WAIT watchdog that answers err 3 after TIMEOUT cycles.
module float_copro_seq #(
    parameter int NE      = 8,
    parameter int NM      = 23,
    parameter int TIMEOUT = 64,
    localparam int W      = 1 + NE + NM
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cmd_valid_i,
    output logic         cmd_ready_o,
    input  logic [2:0]   cmd_opcode_i,
    input  logic [W-1:0] cmd_op1_i,
    input  logic [W-1:0] cmd_op2_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [W-1:0] rsp_result_o,
    output logic [1:0]   rsp_err_o,
    output logic         fu_start_o,
    output logic [1:0]   fu_sel_o,
    output logic [W-1:0] fu_op1_o,
    output logic [W-1:0] fu_op2_o,
    input  logic         fu_done_i,
    input  logic [W-1:0] fu_result_i
);

    typedef enum logic [2:0] {S_IDLE, S_DECODE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t       state_q, state_d;
    logic [2:0]   opc_q, opc_d;
    logic [W-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
    logic [1:0]   err_q, err_d, sel_q, sel_d;
    logic         z1, z2, sx;

    // Zero ignores the sign bit: +0 and -0 both take the fast paths.
    function automatic logic is_zero(input logic [W-1:0] v);
        return v[W-2:0] == '0;
    endfunction

    function automatic logic [W-1:0] signed_zero(input logic s);
        return {s, {(W-1){1'b0}}};
    endfunction

    function automatic logic [W-1:0] signed_inf(input logic s);
        return {s, {NE{1'b1}}, {NM{1'b0}}};
    endfunction

    assign z1 = is_zero(op1_q);
    assign z2 = is_zero(op2_q);
    assign sx = op1_q[W-1] ^ op2_q[W-1];

`ifdef FLOAT_COPRO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          limit;
    assign limit = (cnt_q == CW'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        op1_d   = op1_q;
        op2_d   = op2_q;
        res_d   = res_q;
        err_d   = err_q;
        sel_d   = sel_q;
`ifdef FLOAT_COPRO_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    opc_d   = cmd_opcode_i;
                    op1_d   = cmd_op1_i;
                    op2_d   = cmd_op2_i;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = S_RESP;
                err_d   = 2'd0;
                if (opc_q[2]) begin
                    res_d = '0;
                    err_d = 2'd1;
                end else if (opc_q == 3'd2 && (z1 || z2)) begin
                    res_d = signed_zero(sx);
                end else if (opc_q == 3'd3 && z2) begin
                    res_d = signed_inf(sx);
                    err_d = 2'd2;
                end else if (opc_q == 3'd3 && z1) begin
                    res_d = signed_zero(sx);
                end else if (!opc_q[1] && z1) begin
                    res_d = {op2_q[W-1] ^ opc_q[0], op2_q[W-2:0]};
                end else if (!opc_q[1] && z2) begin
                    res_d = op1_q;
                end else begin
                    sel_d   = opc_q[1:0];
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef FLOAT_COPRO_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            S_WAIT: begin
                // A done arriving on the limit cycle takes priority over the watchdog.
                if (fu_done_i) begin
                    res_d   = fu_result_i;
                    err_d   = 2'd0;
                    state_d = S_RESP;
                end
`ifdef FLOAT_COPRO_TIMEOUT_EN
                else if (limit) begin
                    res_d   = signed_inf(1'b0);
                    err_d   = 2'd3;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            opc_q   <= '0;
            op1_q   <= '0;
            op2_q   <= '0;
            res_q   <= '0;
            err_q   <= '0;
            sel_q   <= '0;
`ifdef FLOAT_COPRO_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            op1_q   <= op1_d;
            op2_q   <= op2_d;
            res_q   <= res_d;
            err_q   <= err_d;
            sel_q   <= sel_d;
`ifdef FLOAT_COPRO_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign cmd_ready_o  = (state_q == S_IDLE);
    assign rsp_valid_o  = (state_q == S_RESP);
    assign fu_start_o   = (state_q == S_ISSUE);
    assign fu_sel_o     = sel_q;
    assign fu_op1_o     = op1_q;
    assign fu_op2_o     = op2_q;
    assign rsp_result_o = res_q;
    assign rsp_err_o    = err_q;

endmodule

// File: tb/tb_float_copro_seq.sv
// Self-checking bench for float_copro_seq: directed cases plus randomized commands vs a rule-level model.
module tb_float_copro_seq;

    localparam int W   = 32;
    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rst_i;
    logic         cmd_valid_i;
    logic         cmd_ready_o;
    logic [2:0]   cmd_opcode_i;
    logic [W-1:0] cmd_op1_i, cmd_op2_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [W-1:0] rsp_result_o;
    logic [1:0]   rsp_err_o;
    logic         fu_start_o;
    logic [1:0]   fu_sel_o;
    logic [W-1:0] fu_op1_o, fu_op2_o;
    logic         fu_done_i;
    logic [W-1:0] fu_result_i;

    int n_vec = 0;
    int n_err = 0;

    float_copro_seq #(.NE(8), .NM(23), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_opcode_i(cmd_opcode_i),
        .cmd_op1_i(cmd_op1_i), .cmd_op2_i(cmd_op2_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o),
        .fu_start_o(fu_start_o), .fu_sel_o(fu_sel_o),
        .fu_op1_o(fu_op1_o), .fu_op2_o(fu_op2_o),
        .fu_done_i(fu_done_i), .fu_result_i(fu_result_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected response derived directly from the command rules; ures is what the unit would return.
    function automatic void model(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] ures, output bit unit,
                                  output logic [31:0] res, output logic [1:0] err);
        bit za, zb, sx;
        za = (a[30:0] == 31'd0);
        zb = (b[30:0] == 31'd0);
        sx = a[31] ^ b[31];
        unit = 0; res = 32'd0; err = 2'd0;
        case (opc)
            3'd0, 3'd1: begin
                if (za)      res = (opc == 3'd1) ? (b ^ 32'h8000_0000) : b;
                else if (zb) res = a;
                else begin unit = 1; res = ures; end
            end
            3'd2: begin
                if (za || zb) res = {sx, 31'd0};
                else begin unit = 1; res = ures; end
            end
            3'd3: begin
                if (zb) begin res = {sx, 8'hFF, 23'd0}; err = 2'd2; end
                else if (za) res = {sx, 31'd0};
                else begin unit = 1; res = ures; end
            end
            default: err = 2'd1;
        endcase
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, ":cmd_ready"}, 32'(cmd_ready_o), 32'd1);
        chk({tag, ":rsp_valid"}, 32'(rsp_valid_o), 32'd0);
        chk({tag, ":result"},    rsp_result_o,     32'd0);
        chk({tag, ":err"},       32'(rsp_err_o),   32'd0);
        chk({tag, ":start"},     32'(fu_start_o),  32'd0);
        chk({tag, ":sel"},       32'(fu_sel_o),    32'd0);
        chk({tag, ":op1"},       fu_op1_o,         32'd0);
        chk({tag, ":op2"},       fu_op2_o,         32'd0);
    endtask

    // One full command. dly: unit answers dly cycles after its start cycle (0 = never).
    // hold: cycles rsp_ready_i stays low once the response is up (0 = ready held high throughout).
    task automatic run_cmd(input logic [2:0] opc, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ures, input int dly, input int hold,
                           input bit spur, input string tag);
        bit          unit, busy_rdy;
        logic [31:0] er;
        logic [1:0]  ee;
        int          starts, start_at, done_at, rsp_at;
        model(opc, a, b, ures, unit, er, ee);
        if (unit && dly == 0) begin er = 32'h7F80_0000; ee = 2'd3; end
        @(negedge clk);
        chk({tag, ":accept_ready"}, 32'(cmd_ready_o), 32'd1);
        cmd_valid_i = 1; cmd_opcode_i = opc; cmd_op1_i = a; cmd_op2_i = b;
        rsp_ready_i = (hold == 0);
        starts = 0; start_at = -1; done_at = -1; rsp_at = -1; busy_rdy = 0;
        for (int c = 1; c <= 200 && rsp_at < 0; c++) begin
            @(negedge clk);
            fu_done_i = 0;
            if (cmd_ready_o) busy_rdy = 1;
            if (rsp_valid_o) rsp_at = c;
            else begin
                if (fu_start_o) begin
                    starts++;
                    start_at = c;
                    chk({tag, ":sel"}, 32'(fu_sel_o), 32'(opc[1:0]));
                    chk({tag, ":op1"}, fu_op1_o, a);
                    chk({tag, ":op2"}, fu_op2_o, b);
                end
                if (spur && (c == 1 || c == start_at)) begin
                    fu_done_i = 1; fu_result_i = $urandom;
                end else if (start_at > 0 && dly > 0 && c == start_at + dly) begin
                    fu_done_i = 1; fu_result_i = ures; done_at = c;
                end
            end
            // Junk commands while busy must not be taken.
            cmd_valid_i = 1'($urandom_range(0, 1));
            cmd_opcode_i = 3'($urandom); cmd_op1_i = $urandom; cmd_op2_i = $urandom;
        end
        chk({tag, ":ready_while_busy"}, 32'(busy_rdy), 32'd0);
        if (rsp_at < 0) begin
            chk({tag, ":rsp_never_valid"}, 32'd0, 32'd1);
        end else begin
            chk({tag, ":start_pulses"}, 32'(starts), unit ? 32'd1 : 32'd0);
            if (!unit)         chk({tag, ":latency_fast"}, 32'(rsp_at), 32'd2);
            else if (ee == 3)  chk({tag, ":latency_tmo"},  32'(rsp_at), 32'(start_at + TMO + 1));
            else               chk({tag, ":latency_unit"}, 32'(rsp_at), 32'(done_at + 1));
            chk({tag, ":result"}, rsp_result_o, er);
            chk({tag, ":err"}, 32'(rsp_err_o), 32'(ee));
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                cmd_valid_i = 1'($urandom_range(0, 1));
                chk({tag, ":hold_valid"},  32'(rsp_valid_o), 32'd1);
                chk({tag, ":hold_result"}, rsp_result_o,     er);
                chk({tag, ":hold_ready"},  32'(cmd_ready_o), 32'd0);
            end
            rsp_ready_i = 1;
            @(negedge clk);
            cmd_valid_i = 0; rsp_ready_i = 0;
            chk({tag, ":after_valid"}, 32'(rsp_valid_o), 32'd0);
            chk({tag, ":after_ready"}, 32'(cmd_ready_o), 32'd1);
        end
        cmd_valid_i = 0; fu_done_i = 0;
    endtask

    function automatic logic [31:0] rnd_op();
        if ($urandom_range(0, 3) == 0) return {1'($urandom), 31'd0};
        return $urandom;
    endfunction

    initial begin
        rst_i = 1; cmd_valid_i = 0; cmd_opcode_i = 0; cmd_op1_i = 0; cmd_op2_i = 0;
        rsp_ready_i = 0; fu_done_i = 0; fu_result_i = 0;
        repeat (2) @(negedge clk);
        check_reset_vals("por");
        rst_i = 0;

        run_cmd(3'd2, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4, 0, 0, "mul_unit");
        run_cmd(3'd2, 32'h8000_0000, 32'h3F80_0000, 32'h1234_5678, 4, 0, 0, "mul_negzero");
        run_cmd(3'd3, 32'h3F80_0000, 32'h0000_0000, 32'h1234_5678, 4, 1, 1, "div_by_zero");
        run_cmd(3'd5, 32'h3F80_0000, 32'h4000_0000, 32'h1234_5678, 4, 3, 0, "illegal_op");
        run_cmd(3'd1, 32'h0000_0000, 32'h4000_0000, 32'h1234_5678, 4, 3, 0, "sub_zero_op1");

        // Reset while the unit is busy; its late done must be ignored.
        @(negedge clk);
        cmd_valid_i = 1; cmd_opcode_i = 3'd0; cmd_op1_i = 32'h3F80_0000; cmd_op2_i = 32'h4000_0000;
        @(negedge clk); cmd_valid_i = 0;
        @(negedge clk);
        chk("rst_mid:issue_start", 32'(fu_start_o), 32'd1);
        @(negedge clk);
        rst_i = 1;
        #1;
        check_reset_vals("rst_mid");
        @(negedge clk); rst_i = 0;
        @(negedge clk);
        fu_done_i = 1; fu_result_i = 32'hDEAD_BEEF;
        @(negedge clk); fu_done_i = 0;
        repeat (2) begin
            @(negedge clk);
            check_reset_vals("rst_late_done");
        end

`ifdef FLOAT_COPRO_TIMEOUT_EN
        run_cmd(3'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0, 0, 0, "tmo_never");
        run_cmd(3'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, TMO, 0, 0, "tmo_done_at_limit");
`endif

        for (int i = 0; i < 60; i++) begin
            run_cmd(3'($urandom_range(0, 7)), rnd_op(), rnd_op(), $urandom,
                    $urandom_range(1, 6), $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
